// File: rtl/regfile_pkg.sv
// Shared types for the parametrised register file: init fill mode and sequencer state.
package regfile_pkg;

  typedef enum logic {INIT_INDEX, INIT_ZERO} init_mode_t;

  typedef enum logic {INIT, READY} rf_state_t;

endpackage

// File: rtl/regfile_init_seq.sv
// Reset-driven init sequencer: walks cnt over every entry once, then parks in READY.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 32,
  parameter init_mode_t  INIT_MODE = INIT_INDEX,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             init_we,
  output logic [AW-1:0]    init_wa,
  output logic [WIDTH-1:0] init_wd,
  output logic             busy
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // A reset edge must not also commit a fill write.
  assign busy    = (state_q == INIT);
  assign init_we = busy && !reset;
  assign init_wa = cnt_q;
  assign init_wd = (INIT_MODE == INIT_INDEX) ? WIDTH'(cnt_q) : '0;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with zero register, optional bypass and init fill.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned NREAD       = 2,
  parameter int unsigned NWRITE      = 1,
  parameter bit          ZERO_REG_EN = 1'b1,
  parameter bit          BYPASS      = 1'b0,
  parameter init_mode_t  INIT_MODE   = INIT_INDEX,
  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREAD-1:0][AW-1:0]     ra,
  output logic [NREAD-1:0][WIDTH-1:0]  rd,
  input  logic [NWRITE-1:0]            we,
  input  logic [NWRITE-1:0][AW-1:0]    wa,
  input  logic [NWRITE-1:0][WIDTH-1:0] wd,
  output logic                         busy
);

  logic             init_we;
  logic [AW-1:0]    init_wa;
  logic [WIDTH-1:0] init_wd;

  regfile_init_seq #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .INIT_MODE (INIT_MODE)
  ) u_init_seq (
    .clk     (clk),
    .reset   (reset),
    .init_we (init_we),
    .init_wa (init_wa),
    .init_wd (init_wd),
    .busy    (busy)
  );

  logic [WIDTH-1:0]            mem_q [DEPTH];
  logic [NWRITE-1:0]           wr_en;
  logic [NWRITE-1:0][AW-1:0]   wr_addr;
  logic [NWRITE-1:0][WIDTH-1:0] wr_data;

  // While busy the sequencer owns write lane 0 and all port writes are suppressed.
  always_comb begin
    wr_en   = '0;
    wr_addr = wa;
    wr_data = wd;
    if (busy) begin
      wr_en[0]   = init_we;
      wr_addr[0] = init_wa;
      wr_data[0] = init_wd;
    end else begin
      wr_en = we;
    end
    if (ZERO_REG_EN) begin
      for (int unsigned p = 0; p < NWRITE; p++) begin
        if (wr_addr[p] == AW'(DEPTH - 1)) wr_en[p] = 1'b0;
      end
    end
  end

  // Ascending lane order makes the highest-numbered port win an address conflict.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NWRITE; p++) begin
      if (wr_en[p]) mem_q[wr_addr[p]] <= wr_data[p];
    end
  end

  always_comb begin
    rd = '0;
    if (!busy) begin
      for (int unsigned k = 0; k < NREAD; k++) begin
        rd[k] = mem_q[ra[k]];
        if (BYPASS) begin
          for (int unsigned p = 0; p < NWRITE; p++) begin
            if (we[p] && (wa[p] == ra[k])) rd[k] = wd[p];
          end
        end
        if (ZERO_REG_EN && (ra[k] == AW'(DEPTH - 1))) rd[k] = '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised + directed bench for regfile_param against an array-level reference model.
module tb_regfile_param;
  import regfile_pkg::*;

  localparam int W = 64;
  localparam int D = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [3:0][4:0]  ra = '0;
  logic [1:0]       we = '0;
  logic [1:0][4:0]  wa = '0;
  logic [1:0][W-1:0] wd = '0;
  logic [1:0][W-1:0] rd0;
  logic [3:0][W-1:0] rd1;
  logic             busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_param #(
    .WIDTH(W), .DEPTH(D), .NREAD(2), .NWRITE(2),
    .ZERO_REG_EN(1'b1), .BYPASS(1'b0), .INIT_MODE(INIT_INDEX)
  ) dut0 (
    .clk(clk), .reset(reset), .ra(ra[1:0]), .rd(rd0),
    .we(we), .wa(wa), .wd(wd), .busy(busy0)
  );

  regfile_param #(
    .WIDTH(W), .DEPTH(D), .NREAD(4), .NWRITE(2),
    .ZERO_REG_EN(1'b1), .BYPASS(1'b1), .INIT_MODE(INIT_INDEX)
  ) dut1 (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd1),
    .we(we), .wa(wa), .wd(wd), .busy(busy1)
  );

  // Reference model: register contents as plain array, fill progress as a position.
  logic [W-1:0] m_mem [D];
  bit           m_busy  = 1'b1;
  bit           m_valid = 1'b0;
  int           m_pos   = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy  = 1'b1;
      m_pos   = 0;
      m_valid = 1'b1;
    end else if (m_busy) begin
      if (m_pos != D - 1) m_mem[m_pos] = W'(m_pos);
      m_pos++;
      if (m_pos == D) m_busy = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (we[p] && wa[p] != 5'(D - 1)) m_mem[wa[p]] = wd[p];
    end
  end

  function automatic logic [W-1:0] exp_rd(input logic [4:0] a, input bit byp);
    logic [W-1:0] v;
    if (m_busy || a == 5'(D - 1)) return '0;
    v = m_mem[a];
    if (byp)
      for (int p = 0; p < 2; p++)
        if (we[p] && wa[p] == a) v = wd[p];
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy0", W'(busy0), W'(m_busy));
      chk("busy1", W'(busy1), W'(m_busy));
      for (int k = 0; k < 2; k++) chk("model_rd0", rd0[k], exp_rd(ra[k], 1'b0));
      for (int k = 0; k < 4; k++) chk("model_rd1", rd1[k], exp_rd(ra[k], 1'b1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string name, input int want);
    int cycles = 0;
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy0) done = 1'b1;
      else cycles++;
      if (!done) tick();
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: busy never dropped", name);
    end
    chk(name, W'(cycles), W'(want));
    tick();
  endtask

  initial begin
    repeat (2) tick();

    // Init fill
    reset = 1'b1; tick(); reset = 1'b0;
    count_busy("init_busy_len", 32);
    for (int i = 0; i < D; i++) begin
      for (int k = 0; k < 4; k++) ra[k] = 5'(i);
      @(negedge clk);
      chk("sweep_p0", rd0[0], (i == 31) ? 64'd0 : 64'(i));
      chk("sweep_p1", rd0[1], (i == 31) ? 64'd0 : 64'(i));
      chk("sweep_b3", rd1[3], (i == 31) ? 64'd0 : 64'(i));
      tick();
    end

    // Write then read
    we = 2'b01; wa[0] = 5'd5; wd[0] = 64'd848; ra[0] = 5'd5;
    @(negedge clk);
    chk("wr_nobyp_same", rd0[0], 64'd5);
    chk("wr_byp_same", rd1[0], 64'd848);
    tick(); we = '0;
    @(negedge clk);
    chk("wr_nobyp_next", rd0[0], 64'd848);
    tick();

    // Zero register
    we = 2'b01; wa[0] = 5'd31; wd[0] = 64'hDEAD_BEEF; ra[0] = 5'd31; ra[1] = 5'd30;
    @(negedge clk);
    chk("zero_byp_same", rd1[0], 64'd0);
    chk("zero_nobyp_same", rd0[0], 64'd0);
    tick(); we = '0;
    @(negedge clk);
    chk("zero_next", rd0[0], 64'd0);
    chk("zero_r30", rd0[1], 64'd30);
    tick();

    // Write conflict
    we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 64'd1; wd[1] = 64'd2; ra[0] = 5'd7;
    @(negedge clk);
    chk("conflict_byp", rd1[0], 64'd2);
    tick(); we = '0;
    @(negedge clk);
    chk("conflict_next", rd0[0], 64'd2);
    tick();

    // Reset mid-init, with a port write attempted while busy
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin we = 2'b01; wa[0] = 5'd3; wd[0] = 64'd99; end
      else we = '0;
      tick();
    end
    we = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    count_busy("reinit_busy_len", 32);
    ra[0] = 5'd3;
    @(negedge clk);
    chk("busy_write_ignored", rd0[0], 64'd3);
    tick();

    // Port independence
    ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3; ra[3] = 5'd1;
    @(negedge clk);
    chk("indep0", rd1[0], 64'd1);
    chk("indep1", rd1[1], 64'd2);
    chk("indep2", rd1[2], 64'd3);
    chk("indep3", rd1[3], 64'd1);
    tick();

    // Random traffic, occasional resets
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      we    = reset ? 2'b00 : 2'($urandom_range(0, 3));
      wa[0] = 5'($urandom_range(0, 31));
      wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : 5'($urandom_range(0, 31));
      wd[0] = {$urandom, $urandom};
      wd[1] = {$urandom, $urandom};
      for (int k = 0; k < 4; k++)
        ra[k] = ($urandom_range(0, 2) == 0) ? wa[$urandom_range(0, 1)] : 5'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0; we = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the single-write, two-read 64-bit register file of the single-cycle datapath.
- Generalises width, depth, read-port count and write-port count.
- Adds a hardwired zero register, optional write-to-read bypass, and a reset-driven init sequencer that fills the array one entry per cycle.
- Sits in the decode stage and feeds the ALU operands. It is the drop-in register file for the pipelined core.

Parameters:
- WIDTH, 64: data width in bits.
- DEPTH, 32: number of registers. Power of two, minimum 2.
- NREAD, 2: number of read ports, 1..4.
- NWRITE, 1: number of write ports, 1..2.
- ZERO_REG_EN, 1: if 1, register DEPTH-1 always reads 0 and ignores writes.
- BYPASS, 0: if 1, a same-cycle write is forwarded to matching reads.
- INIT_MODE, INIT_INDEX: INIT_INDEX loads register i with value i; INIT_ZERO loads 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ra  in  NREAD x clog2(DEPTH)  read addresses.
- rd  out  NREAD x WIDTH  read data, combinational.
- we  in  NWRITE  write enables.
- wa  in  NWRITE x clog2(DEPTH)  write addresses.
- wd  in  NWRITE x WIDTH  write data.
- busy  out  1  high while the init sequence runs.

Behaviour:
- Reset: clk and reset as above. Every state update happens on the rising edge of clk. When reset is high at an edge: state<=INIT, cnt<=0, busy=1. Array contents are not otherwise cleared by reset.
- FSM states: INIT and READY.
  - INIT, each edge with reset low: reg[cnt] <= (INIT_MODE==INIT_INDEX ? cnt zero-extended to WIDTH : 0); cnt <= cnt+1.
  - INIT to READY: on the edge where cnt==DEPTH-1 is written.
  - READY to INIT: only via reset.
- busy timing: busy = (state==INIT). After reset is released, busy stays high for exactly DEPTH cycles.
- Reset mid-INIT: restarts at cnt=0, and the full DEPTH cycles are needed again.
- Port writes while busy: ignored. The we, wa and wd inputs have no effect in INIT.
- Reads while busy: all rd ports return 0.
- Writes in READY:
  - For each port p with we[p]=1, reg[wa[p]] <= wd[p] at the edge.
  - Same-address conflict when NWRITE=2 and both ports are enabled: port 1 wins.
- Reads in READY:
  - Combinational: rd[k] = reg[ra[k]].
  - With BYPASS=1, if any enabled write port has wa==ra[k], rd[k]=wd of that port (port 1 has priority). The forwarded value is the value the register will hold after the edge.
  - With BYPASS=0, rd[k] returns the pre-edge value, and the new value is visible in the following cycle.
- Zero register (ZERO_REG_EN=1):
  - rd[k]=0 when ra[k]==DEPTH-1, including the bypass case.
  - Writes to DEPTH-1 are dropped.
  - The INIT write to DEPTH-1 is dropped too, so its storage may hold X, but the read is still 0.
- Read ports are independent: any number of ports may read the same address.
- Latency: write-to-read is 1 cycle, or 0 cycles with BYPASS=1. Read latency is 0 cycles (combinational).
- Address range: out-of-range addresses cannot occur (DEPTH is a power of two).

Decomposition:
- Shared package regfile_pkg holds:
  - typedef enum init_mode_t {INIT_INDEX, INIT_ZERO};
  - typedef enum logic {INIT, READY} rf_state_t.
- Sub-module regfile_init_seq holds the FSM, the cnt counter and busy. Its outputs are init_we, init_wa and init_wd.
- The top level muxes the init write path against the port write paths using busy.
- The array, read muxes, bypass and zero-register logic stay in regfile_param.

Test Plan:
All scenarios use WIDTH=64, DEPTH=32, NREAD=2, NWRITE=2, INIT_MODE=INIT_INDEX unless stated.
1. Init fill: reset high for 1 cycle, then release -> busy=1 for exactly 32 cycles. Afterwards, sweeping ra[0]=ra[1]=i for i=0..30 gives rd=i on both ports; i=31 gives rd=0. No mismatches allowed.
2. Write then read: we[0]=1, wa[0]=5, wd[0]=848.
   - BYPASS=0: same cycle rd[0] (ra=5) =5; next cycle =848.
   - BYPASS=1: same cycle rd[0]=848.
3. Zero register: write 64'hDEAD_BEEF to 31 -> rd from 31 is 0 in the same cycle (BYPASS=1) and in the next cycle. Register 30 is unchanged (still 30).
4. Write conflict: wa[0]=wa[1]=7, wd[0]=1, wd[1]=2, both enabled -> reg7 reads 2 next cycle. With BYPASS=1, the same-cycle read also gives 2.
5. Reset mid-init: assert reset when cnt=10 -> busy stays high for 32 more cycles after release. Meanwhile a port write of 99 to reg 3 while busy -> reg3 reads 3 once READY.
6. Port independence: NREAD=4, ra={1,2,3,1} after init -> rd={1,2,3,1} in the same cycle.
